// File: rtl/lut_interp_pkg.sv
// Shared types and defaults for the LUT interpolation engine.
// Holds the FSM state set, search-mode selectors and parameter defaults.
package lut_interp_pkg;

  localparam int SEARCH_LINEAR = 0;
  localparam int SEARCH_BINARY = 1;

  localparam int DEF_XW         = 48;
  localparam int DEF_YW         = 64;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DEPTH      = 128;
  localparam int DEF_SEARCH_BIN = SEARCH_BINARY;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    COMPARE,
    FETCH_HI,
    DIVIDE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_FIRST,
    PH_HI,
    PH_MID
  } phase_e;

endpackage

// File: rtl/lut_interp_div.sv
// Sequential signed divider: signed numerator over positive denominator,
// restoring, one quotient bit per cycle, quotient truncated toward zero.
module lut_interp_div #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic signed [NW:0] num,
  input  logic [DW-1:0]     den,
  output logic              busy,
  output logic              done,
  output logic signed [NW:0] quo
);

  localparam int CW = $clog2(NW + 1);

  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] den_q, den_d;
  logic [NW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;

  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic          ge;
  logic [DW-1:0] rem_n;
  logic [NW-1:0] acc_n;
  logic [NW-1:0] num_abs;

  always_comb begin
    shifted = {rem_q, acc_q[NW-1]};
    diff    = shifted - {1'b0, den_q};
    ge      = !diff[DW];
    rem_n   = ge ? diff[DW-1:0] : shifted[DW-1:0];
    acc_n   = {acc_q[NW-2:0], ge};
    num_abs = num[NW] ? (~num[NW-1:0] + 1'b1) : num[NW-1:0];

    rem_d  = rem_q;
    den_d  = den_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    busy_d = busy_q;

    if (start && !busy_q) begin
      rem_d  = '0;
      den_d  = den;
      acc_d  = num_abs;
      neg_d  = num[NW];
      cnt_d  = CW'(NW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_n;
      acc_d = acc_n;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
    end
  end

  // done flags the final step; quo is that step's result
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quo  = neg_q ? -$signed({1'b0, acc_n}) : $signed({1'b0, acc_n});

endmodule

// File: rtl/lut_interp_engine.sv
// Piecewise-linear lookup: searches an external registered LUT for the
// bracketing segment, then interpolates with a sequential divider.
module lut_interp_engine
  import lut_interp_pkg::*;
#(
  parameter int XW         = DEF_XW,
  parameter int YW         = DEF_YW,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SEARCH_BIN = DEF_SEARCH_BIN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XW-1:0]     req_x,
  output logic [ADDR_W-1:0] LUT_ADDR,
  input  logic [XW+YW-1:0]  LUT_DATA,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [YW-1:0]     out_y,
  output logic              out_sat
);

  localparam int NW = XW + YW;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam bit BIN = (SEARCH_BIN == SEARCH_BINARY);

  state_e st_q, st_d;
  phase_e ph_q, ph_d;

  logic [XW-1:0]     x_q, x_d, xl_q, xl_d, xh_q, xh_d;
  logic [YW-1:0]     yl_q, yl_d, yh_q, yh_d, y_q, y_d;
  logic              sat_q, sat_d;
  logic [ADDR_W-1:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;

  logic [XW-1:0]     lx;
  logic [YW-1:0]     ly;
  logic              go_div;
  logic [XW-1:0]     dx;
  logic [YW:0]       dy;
  logic signed [NW:0] dx_s, dy_s, prod;
  logic [XW-1:0]     den;
  logic              div_busy, div_done;
  logic signed [NW:0] div_quo;

  assign lx = LUT_DATA[NW-1:YW];
  assign ly = LUT_DATA[YW-1:0];

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    x_d    = x_q;
    xl_d   = xl_q;
    yl_d   = yl_q;
    xh_d   = xh_q;
    yh_d   = yh_q;
    y_d    = y_q;
    sat_d  = sat_q;
    addr_d = addr_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    go_div = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (req_valid) begin
          x_d    = req_x;
          addr_d = '0;
          lo_d   = '0;
          hi_d   = LAST;
          ph_d   = PH_FIRST;
          st_d   = PROBE;
        end
      end
      PROBE, FETCH_HI: st_d = COMPARE;
      COMPARE: begin
        if (x_q == lx) begin
          y_d   = ly;
          sat_d = 1'b0;
          st_d  = DONE;
        end else if (x_q < lx) begin
          if (addr_q == '0) begin
            y_d   = ly;
            sat_d = 1'b1;
            st_d  = DONE;
          end else begin
            xh_d = lx;
            yh_d = ly;
            hi_d = addr_q;
            if (!BIN || (hi_d - lo_d) == ONE) begin
              go_div = 1'b1;
            end else begin
              addr_d = ADDR_W'(({1'b0, lo_d} + {1'b0, hi_d}) >> 1);
              ph_d   = PH_MID;
              st_d   = PROBE;
            end
          end
        end else begin
          xl_d = lx;
          yl_d = ly;
          lo_d = addr_q;
          if (addr_q == LAST) begin
            y_d   = ly;
            sat_d = 1'b1;
            st_d  = DONE;
          end else if (!BIN) begin
            addr_d = addr_q + ONE;
            st_d   = PROBE;
          end else if (ph_q == PH_FIRST) begin
            addr_d = LAST;
            ph_d   = PH_HI;
            st_d   = FETCH_HI;
          end else if ((hi_d - lo_d) == ONE) begin
            go_div = 1'b1;
          end else begin
            addr_d = ADDR_W'(({1'b0, lo_d} + {1'b0, hi_d}) >> 1);
            ph_d   = PH_MID;
            st_d   = PROBE;
          end
        end
        if (go_div) st_d = DIVIDE;
      end
      DIVIDE: begin
        if (div_done) begin
          y_d   = YW'({{(NW + 1 - YW){1'b0}}, yl_q} + div_quo);
          sat_d = 1'b0;
          st_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // operands follow the just-decided segment so divide starts this cycle
  always_comb begin
    dx   = x_q - xl_d;
    dy   = {1'b0, yh_d} - {1'b0, yl_d};
    dx_s = {{YW{1'b0}}, 1'b0, dx};
    dy_s = {{XW{dy[YW]}}, dy};
    prod = dx_s * dy_s;
    den  = xh_d - xl_d;
  end

  lut_interp_div #(
    .NW(NW),
    .DW(XW)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .start(go_div && !div_busy),
    .num  (prod),
    .den  (den),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      ph_q   <= PH_FIRST;
      x_q    <= '0;
      xl_q   <= '0;
      yl_q   <= '0;
      xh_q   <= '0;
      yh_q   <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
      addr_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      x_q    <= x_d;
      xl_q   <= xl_d;
      yl_q   <= yl_d;
      xh_q   <= xh_d;
      yh_q   <= yh_d;
      y_q    <= y_d;
      sat_q  <= sat_d;
      addr_q <= addr_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
    end
  end

  assign req_ready = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign out_y     = y_q;
  assign out_sat   = sat_q;
  assign LUT_ADDR  = addr_q;

endmodule

// File: doc/lut_interp_engine.md
LUT_INTERP_ENGINE -- requirements
Module: lut_interp_engine

Interface
REQ-001 SHALL have parameter XW, default 48: table/query x width, unsigned.
REQ-002 SHALL have parameter YW, default 64: table y width; result width.
REQ-003 SHALL have parameter ADDR_W, default 7: LUT address width.
REQ-004 SHALL have parameter DEPTH, default 128: number of valid table entries, 2 <= DEPTH <= 2^ADDR_W.
REQ-005 SHALL have parameter SEARCH_BIN, default 1: 1 selects binary search, 0 selects linear search.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_x (input, XW): query handshake.
REQ-009 SHALL have ports LUT_ADDR (output, ADDR_W) and LUT_DATA (input, XW+YW): LUT_DATA = {x_i, y_i}, valid one cycle after LUT_ADDR is presented.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_y (output, YW), out_sat (output, 1).

Function
REQ-011 Table x_i SHALL be strictly increasing; y_i is unconstrained.
REQ-012 A query SHALL be accepted on a cycle with req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-013 FSM states SHALL be IDLE, PROBE, COMPARE, FETCH_HI, DIVIDE, DONE.
REQ-014 PROBE SHALL drive LUT_ADDR; COMPARE SHALL evaluate LUT_DATA on the following cycle, giving 2 cycles per probe.
REQ-015 Search SHALL find index i with x_i <= x < x_{i+1}; in linear mode it probes i = 0,1,2,...; in binary mode it uses lo/hi bisection over [0, DEPTH-1].
REQ-016 Exact hit (x == x_i) SHALL go directly to DONE with out_y = y_i and out_sat = 0, with no divide.
REQ-017 For x < x_0, out_y SHALL be y_0; for x > x_{DEPTH-1}, out_y SHALL be y_{DEPTH-1}; out_sat SHALL be 1 in both cases.
REQ-018 Interpolation SHALL compute out_y = y_i + trunc0(((x - x_i) * (y_{i+1} - y_i)) / (x_{i+1} - x_i)), using a signed product of XW+YW+1 bits and the quotient truncated toward zero.
REQ-019 The result SHALL wrap modulo 2^YW.
REQ-020 DIVIDE SHALL take exactly XW+YW cycles (restoring, one quotient bit per cycle).
REQ-021 Latency SHALL be no more than 2*(ceil(log2 DEPTH)+2)+XW+YW+2 cycles in binary mode, and no more than 2*(DEPTH+1)+XW+YW+2 cycles in linear mode.
REQ-022 In DONE, out_valid SHALL be 1; out_y and out_sat SHALL hold stable until out_ready; return to IDLE occurs on the cycle out_valid && out_ready.
REQ-023 out_ready low SHALL stall indefinitely without loss of the result.
REQ-024 req_x SHALL be captured at acceptance; later changes on req_x SHALL have no effect.
REQ-025 req_valid asserted outside IDLE SHALL be ignored, and no second query SHALL be queued.
REQ-026 LUT_ADDR SHALL never exceed DEPTH-1.

Reset
REQ-027 reset SHALL force IDLE, req_ready = 1, out_valid = 0, out_y = 0, out_sat = 0, LUT_ADDR = 0, and clear divider state.
REQ-028 reset asserted mid-search or mid-divide SHALL abort the query with no out_valid pulse.
REQ-029 The first query SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-030 Package lut_interp_pkg SHALL hold the FSM state enum, the SEARCH_LINEAR/SEARCH_BINARY constants and the default parameter values.
REQ-031 Sub-module lut_interp_div SHALL implement the sequential signed divider with start/busy/done.
REQ-032 The engine SHALL contain no combinational divider and no multi-cycle paths.

Verification
Common setup for all scenarios: XW=16, YW=16, DEPTH=4, x = {0,100,200,300}, y = {1000,800,800,1400}; run each in both SEARCH_BIN modes.
REQ-033 req_x=50 -> out_y=900, out_sat=0.
REQ-034 req_x=33 -> out_y=934 (truncation toward zero); req_x=250 -> out_y=1100.
REQ-035 req_x=200 -> out_y=800 with DIVIDE never entered; req_x=0 -> out_y=1000, out_sat=0.
REQ-036 req_x=350 -> out_y=1400, out_sat=1.
REQ-037 req_x=150 with out_ready held low for 20 cycles -> out_y=800 stable throughout, req_ready=0, and a concurrent req_valid is ignored.
REQ-038 reset pulsed during DIVIDE -> out_valid never asserts, req_ready=1 on the next cycle, and a following req_x=50 returns 900.
